// File: rtl/lap_pkg.sv
// ---------------------------------------------------------------------------
// lap_pkg -- shared definitions for the lap_recall stopwatch display block.
//
// Contents:
//   SEG_W   : width of one 7-segment digit code
//   DIGITS  : number of digits in one display snapshot
//   SNAP_W  : width of one packed snapshot (DIGITS * SEG_W = 42)
//   state_t : display mode (LIVE shows the running digits, RECALL a lap)
//   snap_t  : one packed snapshot; digit 1 occupies the least significant
//             SEG_W bits, digit 6 the most significant
//   pack_digits : helper that builds a snap_t from six digit codes
// ---------------------------------------------------------------------------
package lap_pkg;

    localparam int SEG_W  = 7;
    localparam int DIGITS = 6;
    localparam int SNAP_W = SEG_W * DIGITS;

    typedef enum logic {
        LIVE   = 1'b0,
        RECALL = 1'b1
    } state_t;

    typedef logic [SNAP_W-1:0] snap_t;

    function automatic snap_t pack_digits(
        input logic [SEG_W-1:0] d1,
        input logic [SEG_W-1:0] d2,
        input logic [SEG_W-1:0] d3,
        input logic [SEG_W-1:0] d4,
        input logic [SEG_W-1:0] d5,
        input logic [SEG_W-1:0] d6
    );
        return {d6, d5, d4, d3, d2, d1};
    endfunction

endpackage

// File: rtl/edge_det.sv
// ---------------------------------------------------------------------------
// edge_det -- rising-edge detector for one debounced button level.
//
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   level : debounced button level
//   rise  : high for the cycle in which level is 1 and its registered copy 0
//
// The history register resets to 1, so a button that is already held when
// reset is released is treated as "was pressed" and yields no edge.
// ---------------------------------------------------------------------------
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic hist;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values, independent of the order of blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 1'b1;
        end else begin
            hist <= level;
        end
    end

    assign rise = level & ~hist;

endmodule

// File: rtl/lap_recall.sv
// ---------------------------------------------------------------------------
// lap_recall -- lap snapshot store and recall for a 6-digit 7-seg display.
//
// Parameters:
//   DEPTH          : number of stored laps (power of 2, 2..16)
//   RECALL_TIMEOUT : idle cycles before RECALL auto-exits (timeout build only)
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   lap_in, recall_in, clear_in  : debounced button levels (act on rising edge)
//   r1..r6                       : live digit codes
//   l1..l6                       : displayed digit codes (registered)
//   lap_idx                      : 1-based ordinal of shown lap, 0 when live
//   lap_cnt                      : number of stored laps, 0..DEPTH
//   recall_mode                  : high while in RECALL
//   full                         : high when lap_cnt == DEPTH
//
// Build option:
//   LAP_RECALL_TIMEOUT_EN : when defined, RECALL returns to LIVE after
//   RECALL_TIMEOUT cycles with no recall step. Undefined (default): RECALL
//   persists until a button ends it, and no timer exists.
//
// Edge priority in one cycle is clear > lap > recall; lower ones are dropped.
// ---------------------------------------------------------------------------
module lap_recall
    import lap_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int RECALL_TIMEOUT = 100_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lap_in,
    input  logic                     recall_in,
    input  logic                     clear_in,
    input  logic [SEG_W-1:0]         r1,
    input  logic [SEG_W-1:0]         r2,
    input  logic [SEG_W-1:0]         r3,
    input  logic [SEG_W-1:0]         r4,
    input  logic [SEG_W-1:0]         r5,
    input  logic [SEG_W-1:0]         r6,
    output logic [SEG_W-1:0]         l1,
    output logic [SEG_W-1:0]         l2,
    output logic [SEG_W-1:0]         l3,
    output logic [SEG_W-1:0]         l4,
    output logic [SEG_W-1:0]         l5,
    output logic [SEG_W-1:0]         l6,
    output logic [$clog2(DEPTH):0]   lap_idx,
    output logic [$clog2(DEPTH):0]   lap_cnt,
    output logic                     recall_mode,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // ---------------- edge detection and priority ----------------
    logic lap_raw, rec_raw, clr_raw;
    logic lap_e, rec_e, clr_e;

    edge_det u_lap_edge (.clk(clk), .rst(rst), .level(lap_in),    .rise(lap_raw));
    edge_det u_rec_edge (.clk(clk), .rst(rst), .level(recall_in), .rise(rec_raw));
    edge_det u_clr_edge (.clk(clk), .rst(rst), .level(clear_in),  .rise(clr_raw));

    assign clr_e = clr_raw;
    assign lap_e = lap_raw & ~clr_raw;
    assign rec_e = rec_raw & ~lap_raw & ~clr_raw;

    // ---------------- state ----------------
    state_t          state;
    logic [AW-1:0]   wr_ptr;
    snap_t           disp;
    snap_t           mem [DEPTH];
    snap_t           live_snap;

    assign live_snap = pack_digits(r1, r2, r3, r4, r5, r6);

`ifdef LAP_RECALL_TIMEOUT_EN
    localparam int TW = (RECALL_TIMEOUT > 1) ? $clog2(RECALL_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(RECALL_TIMEOUT - 1);
    logic [TW-1:0] timer;
    logic          timed_out;

    // Counts idle cycles in RECALL; restarts whenever RECALL is entered or
    // stepped, so the window always measures time since the last recall edge.
    assign timed_out = (state == RECALL) && (timer == TIMER_LAST);
`endif

    // ---------------- next-state decode ----------------
    state_t          nxt_state;
    logic [CW-1:0]   nxt_idx;
    logic [CW-1:0]   nxt_cnt;
    logic [AW-1:0]   nxt_wr;
    logic            capture;
    logic            restart_timer;
    logic [AW-1:0]   rd_addr;

    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_state     = state;
        nxt_idx       = lap_idx;
        nxt_cnt       = lap_cnt;
        nxt_wr        = wr_ptr;
        capture       = 1'b0;
        restart_timer = 1'b0;

        if (clr_e) begin
            nxt_state = LIVE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
            nxt_wr    = '0;
        end else begin
            unique case (state)
                LIVE: begin
                    if (lap_e) begin
                        capture = 1'b1;
                        nxt_wr  = wr_ptr + AW'(1);
                        if (lap_cnt != CNT_FULL) begin
                            nxt_cnt = lap_cnt + CW'(1);
                        end
                    end else if (rec_e && (lap_cnt != '0)) begin
                        nxt_state     = RECALL;
                        nxt_idx       = lap_cnt;
                        restart_timer = 1'b1;
                    end
                end
                RECALL: begin
                    if (lap_e) begin
                        nxt_state = LIVE;
                        nxt_idx   = '0;
                    end else if (rec_e) begin
                        if (lap_idx > CW'(1)) begin
                            nxt_idx       = lap_idx - CW'(1);
                            restart_timer = 1'b1;
                        end else begin
                            nxt_state = LIVE;
                            nxt_idx   = '0;
                        end
                    end
`ifdef LAP_RECALL_TIMEOUT_EN
                    else if (timed_out) begin
                        nxt_state = LIVE;
                        nxt_idx   = '0;
                    end
`endif
                end
                default: begin
                    nxt_state = LIVE;
                    nxt_idx   = '0;
                end
            endcase
        end

        // Oldest stored lap sits at wr_ptr - lap_cnt; ordinal k is k-1 past it.
        // All arithmetic wraps at DEPTH, and lap_cnt == DEPTH truncates to 0.
        rd_addr = wr_ptr - lap_cnt[AW-1:0] + nxt_idx[AW-1:0] - AW'(1);
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LIVE;
            wr_ptr      <= '0;
            lap_cnt     <= '0;
            lap_idx     <= '0;
            recall_mode <= 1'b0;
            full        <= 1'b0;
            disp        <= '0;
        end else begin
            state       <= nxt_state;
            wr_ptr      <= nxt_wr;
            lap_cnt     <= nxt_cnt;
            lap_idx     <= nxt_idx;
            recall_mode <= (nxt_state == RECALL);
            full        <= (nxt_cnt == CNT_FULL);
            disp        <= (nxt_state == RECALL) ? mem[rd_addr] : live_snap;
        end
    end

    // NOTE: the snapshot array has no reset; lap_cnt alone decides which
    // entries are meaningful, so stale contents are never shown.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= live_snap;
        end
    end

`ifdef LAP_RECALL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst || restart_timer || (state != RECALL)) begin
            timer <= '0;
        end else if (!timed_out) begin
            timer <= timer + TW'(1);
        end
    end
`endif

    assign l1 = disp[0*SEG_W +: SEG_W];
    assign l2 = disp[1*SEG_W +: SEG_W];
    assign l3 = disp[2*SEG_W +: SEG_W];
    assign l4 = disp[3*SEG_W +: SEG_W];
    assign l5 = disp[4*SEG_W +: SEG_W];
    assign l6 = disp[5*SEG_W +: SEG_W];

endmodule

// File: tb/tb_lap_recall.sv
// ---------------------------------------------------------------------------
// tb_lap_recall -- scoreboard bench for lap_recall.
// A driver issues one input vector per cycle, advances a list-based lap
// model, and queues the expected outputs; a monitor compares on the falling
// edge. Honours LAP_RECALL_TIMEOUT_EN (uses a 10-cycle timeout then).
// ---------------------------------------------------------------------------
module tb_lap_recall;

    localparam int DEPTH = 8;
`ifdef LAP_RECALL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TO    = 10;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TO    = 100_000_000;
`endif

    typedef struct {
        logic [41:0] l;
        int          idx;
        int          cnt;
        bit          mode;
        bit          full;
    } exp_t;

    logic clk = 1'b0;
    logic rst, lap_in, recall_in, clear_in;
    logic [41:0] rv;
    logic [6:0]  l1, l2, l3, l4, l5, l6;
    logic [3:0]  lap_idx, lap_cnt;
    logic        recall_mode, full;

    always #5 clk = ~clk;

    lap_recall #(.DEPTH(DEPTH), .RECALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .lap_in(lap_in), .recall_in(recall_in), .clear_in(clear_in),
        .r1(rv[6:0]), .r2(rv[13:7]), .r3(rv[20:14]),
        .r4(rv[27:21]), .r5(rv[34:28]), .r6(rv[41:35]),
        .l1(l1), .l2(l2), .l3(l3), .l4(l4), .l5(l5), .l6(l6),
        .lap_idx(lap_idx), .lap_cnt(lap_cnt),
        .recall_mode(recall_mode), .full(full)
    );

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [41:0] laps[$];      // oldest first
    bit  m_recall;
    int  m_idx, m_timer;
    bit  p_lap, p_rec, p_clr;

    function automatic exp_t model_step(input bit r_v, input bit lp, input bit rc,
                                        input bit cl, input logic [41:0] snap);
        exp_t e;
        bit el, er, ec;
        if (r_v) begin
            laps.delete();
            m_recall = 0; m_idx = 0; m_timer = 0;
            p_lap = 1; p_rec = 1; p_clr = 1;
            e.l = '0; e.idx = 0; e.cnt = 0; e.mode = 0; e.full = 0;
            return e;
        end
        ec = cl & ~p_clr;
        el = lp & ~p_lap;
        er = rc & ~p_rec;
        p_clr = cl; p_lap = lp; p_rec = rc;

        if (ec) begin
            laps.delete();
            m_recall = 0; m_idx = 0;
        end else if (el) begin
            if (!m_recall) begin
                laps.push_back(snap);
                if (laps.size() > DEPTH) void'(laps.pop_front());
            end else begin
                m_recall = 0; m_idx = 0;
            end
        end else if (er) begin
            if (!m_recall) begin
                if (laps.size() > 0) begin
                    m_recall = 1; m_idx = laps.size(); m_timer = 0;
                end
            end else if (m_idx > 1) begin
                m_idx--; m_timer = 0;
            end else begin
                m_recall = 0; m_idx = 0;
            end
        end else if (m_recall && TO_EN) begin
            if (m_timer == TO - 1) begin
                m_recall = 0; m_idx = 0;
            end else begin
                m_timer++;
            end
        end

        e.l    = m_recall ? laps[m_idx-1] : snap;
        e.idx  = m_idx;
        e.cnt  = laps.size();
        e.mode = m_recall;
        e.full = (laps.size() == DEPTH);
        return e;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic step(input bit r_v, input bit lp, input bit rc, input bit cl,
                        input logic [41:0] snap);
        rst = r_v; lap_in = lp; recall_in = rc; clear_in = cl; rv = snap;
        exp_q.push_back(model_step(r_v, lp, rc, cl, snap));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [41:0] r1_only(input logic [6:0] d);
        logic [41:0] s;
        s = '0;
        s[6:0] = d;
        return s;
    endfunction

    task automatic lap_pulse(input logic [41:0] snap);
        step(0, 1, 0, 0, snap);
        step(0, 0, 0, 0, snap);
    endtask

    task automatic rec_pulse();
        step(0, 0, 1, 0, 42'h0);
        step(0, 0, 0, 0, 42'h0);
    endtask

    task automatic clr_pulse();
        step(0, 0, 0, 1, 42'h0);
        step(0, 0, 0, 0, 42'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        logic [41:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {l6, l5, l4, l3, l2, l1};
                for (int d = 0; d < 6; d++) begin
                    check($sformatf("l%0d", d + 1), int'(got[d*7 +: 7]), int'(e.l[d*7 +: 7]));
                end
                check("lap_idx", int'(lap_idx), e.idx);
                check("lap_cnt", int'(lap_cnt), e.cnt);
                check("recall_mode", int'(recall_mode), int'(e.mode));
                check("full", int'(full), int'(e.full));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [41:0] all3f;
        int budget;
        rst = 1; lap_in = 0; recall_in = 0; clear_in = 0; rv = '0;
        #1;

        // Reset, then live digits appear one cycle later.
        repeat (3) step(1, 0, 0, 0, 42'h0);
        all3f = {6{7'h3F}};
        repeat (2) step(0, 0, 0, 0, all3f);

        // Three laps, then four recall edges: newest to oldest, then LIVE.
        lap_pulse(r1_only(7'h06));
        lap_pulse(r1_only(7'h5B));
        lap_pulse(r1_only(7'h4F));
        repeat (4) rec_pulse();

        // Nine laps into an 8-deep store: oldest overwritten, full set.
        clr_pulse();
        for (int i = 1; i <= 9; i++) lap_pulse(r1_only(7'(i)));
        repeat (9) rec_pulse();

        // Lap and clear rising together with five stored laps.
        clr_pulse();
        for (int i = 0; i < 5; i++) lap_pulse(42'($urandom) ^ (42'($urandom) << 32));
        step(0, 1, 0, 1, r1_only(7'h55));
        repeat (2) step(0, 0, 0, 0, r1_only(7'h2A));

        // Recall held through reset release; then a recall edge with no laps.
        repeat (2) step(1, 0, 1, 0, 42'h0);
        repeat (3) step(0, 0, 1, 0, r1_only(7'h11));
        step(0, 0, 0, 0, r1_only(7'h12));
        rec_pulse();

        // Randomised traffic, including simultaneous edges and resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 24) == 0),
                 {10'($urandom), 32'($urandom)});
        end
        step(0, 0, 0, 0, 42'h0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 5) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses never compared", exp_q.size());
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
